// File: rtl/strip_occ_writeback.sv
// Strip occupancy table: three candidate reads per cycle, write-back of placements, sweep clear.
// Build option OCC_BYPASS_EN forwards a same-cycle accepted write-back to matching reads.
module strip_occ_writeback #(
  parameter int STRIP_CNT = 16,
  parameter int OCC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_start,
  output logic             busy,
  input  logic             rd_valid,
  input  logic [3:0]       rd_id_1,
  input  logic [3:0]       rd_id_2,
  input  logic [3:0]       rd_id_3,
  output logic             rd_out_valid,
  output logic [3:0]       strip_id_1,
  output logic [3:0]       strip_id_2,
  output logic [3:0]       strip_id_3,
  output logic [OCC_W-1:0] occupied_width_1,
  output logic [OCC_W-1:0] occupied_width_2,
  output logic [OCC_W-1:0] occupied_width_3,
  input  logic             wb_valid,
  input  logic [3:0]       wb_strip_id,
  input  logic [OCC_W-1:0] wb_new_width,
  input  logic             wb_strike,
  output logic [7:0]       place_count
);

  // state | meaning
  // IDLE  | reads and write-backs serviced, clr_start accepted
  // CLEAR | one entry zeroed per cycle, reads and write-backs dropped
  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [3:0] LAST_IDX = 4'(STRIP_CNT - 1);

  state_t           state;
  logic [OCC_W-1:0] occ_tab [STRIP_CNT];
  logic [3:0]       clr_left;
  logic [3:0]       clr_idx;
  logic             rd_acc;
  logic             wr_acc;
  logic [3:0]       cand_id [3];
  logic [OCC_W-1:0] cand_word [3];

  function automatic logic in_range(input logic [3:0] id);
    return {28'd0, id} < 32'(STRIP_CNT);
  endfunction

  // clr_left counts down to the terminal count; the entry index walks up from 0
  assign clr_idx = LAST_IDX - clr_left;
  assign rd_acc  = (state == IDLE) && rd_valid;
  assign wr_acc  = (state == IDLE) && wb_valid && !wb_strike && !clr_start
                   && in_range(wb_strip_id);

  assign cand_id[0] = rd_id_1;
  assign cand_id[1] = rd_id_2;
  assign cand_id[2] = rd_id_3;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      cand_word[i] = '0;
      if (in_range(cand_id[i])) cand_word[i] = occ_tab[cand_id[i]];
`ifdef OCC_BYPASS_EN
      if (wr_acc && (cand_id[i] == wb_strip_id)) cand_word[i] = wb_new_width;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      busy             <= 1'b0;
      clr_left         <= '0;
      place_count      <= '0;
      rd_out_valid     <= 1'b0;
      strip_id_1       <= '0;
      strip_id_2       <= '0;
      strip_id_3       <= '0;
      occupied_width_1 <= '0;
      occupied_width_2 <= '0;
      occupied_width_3 <= '0;
      for (int i = 0; i < STRIP_CNT; i++) occ_tab[i] <= '0;
    end else begin
      rd_out_valid <= rd_acc;
      if (rd_acc) begin
        strip_id_1       <= rd_id_1;
        strip_id_2       <= rd_id_2;
        strip_id_3       <= rd_id_3;
        occupied_width_1 <= cand_word[0];
        occupied_width_2 <= cand_word[1];
        occupied_width_3 <= cand_word[2];
      end
      case (state)
        IDLE: begin
          if (clr_start) begin
            state    <= CLEAR;
            busy     <= 1'b1;
            clr_left <= LAST_IDX;
          end else if (wr_acc) begin
            occ_tab[wb_strip_id] <= wb_new_width;
            if (place_count != 8'hFF) place_count <= place_count + 8'd1;
          end
        end
        CLEAR: begin
          occ_tab[clr_idx] <= '0;
          if (clr_left == LAST_IDX) place_count <= '0;
          if (clr_left == 4'd0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            clr_left <= clr_left - 4'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_strip_occ_writeback.sv
// Self-checking bench for strip_occ_writeback: directed scenarios plus random traffic vs a table model.
// Expected read data follows OCC_BYPASS_EN the same way the design build does.
module tb_strip_occ_writeback;
  localparam int N = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr_start = 1'b0;
  logic       busy;
  logic       rd_valid = 1'b0;
  logic [3:0] rd_id_1 = '0, rd_id_2 = '0, rd_id_3 = '0;
  logic       rd_out_valid;
  logic [3:0] strip_id_1, strip_id_2, strip_id_3;
  logic [7:0] occupied_width_1, occupied_width_2, occupied_width_3;
  logic       wb_valid = 1'b0;
  logic [3:0] wb_strip_id = '0;
  logic [7:0] wb_new_width = '0;
  logic       wb_strike = 1'b0;
  logic [7:0] place_count;

  strip_occ_writeback #(.STRIP_CNT(N), .OCC_W(8)) dut (
    .clk(clk), .rst(rst), .clr_start(clr_start), .busy(busy),
    .rd_valid(rd_valid), .rd_id_1(rd_id_1), .rd_id_2(rd_id_2), .rd_id_3(rd_id_3),
    .rd_out_valid(rd_out_valid),
    .strip_id_1(strip_id_1), .strip_id_2(strip_id_2), .strip_id_3(strip_id_3),
    .occupied_width_1(occupied_width_1), .occupied_width_2(occupied_width_2),
    .occupied_width_3(occupied_width_3),
    .wb_valid(wb_valid), .wb_strip_id(wb_strip_id), .wb_new_width(wb_new_width),
    .wb_strike(wb_strike), .place_count(place_count)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // reference: table contents, accepted-placement count, cycles of clear left
  int   m_tab [N];
  int   m_cnt = 0;
  int   m_busy_left = 0;
  logic exp_rv;
  logic [3:0] exp_id [3];
  logic [7:0] exp_w [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_zero();
    for (int i = 0; i < N; i++) m_tab[i] = 0;
    m_cnt = 0;
  endtask

  task automatic step(input logic rv, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] c, input logic wv, input logic [3:0] wid,
                      input logic [7:0] ww, input logic ws, input logic clr);
    logic       idle;
    logic       hit;
    logic [3:0] ids [3];
    logic [3:0] o_id [3];
    logic [7:0] o_w [3];
    rd_valid = rv; rd_id_1 = a; rd_id_2 = b; rd_id_3 = c;
    wb_valid = wv; wb_strip_id = wid; wb_new_width = ww; wb_strike = ws;
    clr_start = clr;
    ids[0] = a; ids[1] = b; ids[2] = c;
    idle = (m_busy_left == 0);
    hit = idle && wv && !ws && !clr && (int'(wid) < N);
    exp_rv = idle && rv;
    if (exp_rv) begin
      for (int i = 0; i < 3; i++) begin
        exp_id[i] = ids[i];
        exp_w[i] = (int'(ids[i]) < N) ? 8'(m_tab[ids[i]]) : 8'd0;
`ifdef OCC_BYPASS_EN
        if (hit && ids[i] == wid) exp_w[i] = ww;
`endif
      end
    end
    if (idle && clr) begin
      model_zero();
      m_busy_left = N;
    end else begin
      if (m_busy_left > 0) m_busy_left--;
      if (hit) begin
        m_tab[wid] = int'(ww);
        if (m_cnt < 255) m_cnt++;
      end
    end
    @(posedge clk);
    #1;
    o_id[0] = strip_id_1; o_id[1] = strip_id_2; o_id[2] = strip_id_3;
    o_w[0] = occupied_width_1; o_w[1] = occupied_width_2; o_w[2] = occupied_width_3;
    chk("busy", 32'(busy), 32'(m_busy_left > 0));
    chk("rd_out_valid", 32'(rd_out_valid), 32'(exp_rv));
    if (exp_rv) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("strip_id_%0d", i + 1), 32'(o_id[i]), 32'(exp_id[i]));
        chk($sformatf("occupied_width_%0d", i + 1), 32'(o_w[i]), 32'(exp_w[i]));
      end
    end
    if (m_busy_left == 0) chk("place_count", 32'(place_count), 32'(m_cnt));
  endtask

  task automatic idle_step();
    step(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
  endtask

  task automatic rd3(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    step(1'b1, a, b, c, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_rd_out_valid"}, 32'(rd_out_valid), 32'd0);
    chk({tag, "_strip_ids"}, 32'({strip_id_1, strip_id_2, strip_id_3}), 32'd0);
    chk({tag, "_widths"}, 32'({occupied_width_1, occupied_width_2, occupied_width_3}), 32'd0);
    chk({tag, "_place_count"}, 32'(place_count), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0;
    #1;
    check_reset_outputs(tag);
    model_zero();
    m_busy_left = 0;
    #2 rst = 1'b1;
  endtask

  initial begin
    model_zero();
    #1 rst = 1'b0;
    #1 check_reset_outputs("por");
    #5 rst = 1'b1;

    // fresh table reads back zero with ids echoed
    rd3(4'd1, 4'd2, 4'd3);

    // accepted write-back, then duplicate-id reads
    step(1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 4'd5, 8'd40, 1'b0, 1'b0);
    rd3(4'd5, 4'd5, 4'd7);
    chk("dup_read_w1", 32'(occupied_width_1), 32'd40);
    chk("dup_read_w2", 32'(occupied_width_2), 32'd40);
    chk("pc_one", 32'(place_count), 32'd1);

    // strike leaves table and count alone
    step(1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 4'd5, 8'd90, 1'b1, 1'b0);
    rd3(4'd5, 4'd0, 4'd0);
    chk("strike_keep", 32'(occupied_width_1), 32'd40);
    chk("strike_pc", 32'(place_count), 32'd1);

    // read and write-back of the same id in one cycle
    step(1'b1, 4'd3, 4'd0, 4'd0, 1'b1, 4'd3, 8'd25, 1'b0, 1'b0);
`ifdef OCC_BYPASS_EN
    chk("same_cycle_rd", 32'(occupied_width_1), 32'd25);
`else
    chk("same_cycle_rd", 32'(occupied_width_1), 32'd0);
`endif
    rd3(4'd3, 4'd0, 4'd0);
    chk("later_rd", 32'(occupied_width_1), 32'd25);

    // clear wins over a coincident write-back; the coincident read sees old data
    step(1'b1, 4'd5, 4'd3, 4'd9, 1'b1, 4'd9, 8'd77, 1'b0, 1'b1);
    chk("pre_clear_rd", 32'(occupied_width_1), 32'd40);
    for (int k = 0; k < N; k++)
      step(1'b1, 4'(k), 4'd5, 4'd3, 1'b1, 4'(k), 8'(k + 1), 1'b0, 1'b1);
    chk("busy_done", 32'(busy), 32'd0);
    for (int k = 0; k < N; k += 3) rd3(4'(k), 4'((k + 1) % N), 4'((k + 2) % N));
    chk("pc_cleared", 32'(place_count), 32'd0);

    // reset in the middle of a sweep
    step(1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 4'd2, 8'd11, 1'b0, 1'b0);
    step(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b1);
    for (int k = 0; k < 7; k++) idle_step();
    do_reset("mid_clear");
    rd3(4'd2, 4'd1, 4'd0);

    // random traffic
    for (int n = 0; n < 500; n++) begin
      step(1'($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom), 4'($urandom),
           1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 39) == 0));
    end

    // saturation of the placement counter
    step(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b1);
    for (int k = 0; k < N; k++) idle_step();
    for (int n = 0; n < 260; n++)
      step(1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 4'($urandom), 8'($urandom), 1'b0, 1'b0);
    chk("pc_saturated", 32'(place_count), 32'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
